// File: rtl/mine_count_gen.sv
// mine_count_gen: walks the board one cell per clock and writes the number of
// adjacent mines (8-neighbourhood, clipped to the active board edge) into
// num_arr. The mine map and level are snapshotted on start, so the caller may
// change them freely once the scan is under way.
module mine_count_gen #(
  parameter int MAX_DIM = 16,
  parameter int CNT_W   = 4
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        start,
  input  logic [1:0]                                  level,
  input  logic [MAX_DIM-1:0][MAX_DIM-1:0]             mine_arr,
  output logic [MAX_DIM-1:0][MAX_DIM-1:0][CNT_W-1:0]  num_arr,
  output logic                                        busy,
  output logic                                        done
);

  localparam int IW = $clog2(MAX_DIM);
  localparam int NW = IW + 1;   // wide enough to hold MAX_DIM itself

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                                     state_q, state_d;
  logic [IW-1:0]                              x_q, x_d, y_q, y_d;
  logic [1:0]                                 lvl_q;
  logic [MAX_DIM-1:0][MAX_DIM-1:0]            mine_q;
  logic [MAX_DIM-1:0][MAX_DIM-1:0][CNT_W-1:0] num_q;
  logic                                       done_q;
  logic [NW-1:0]                              n_q, n_in;
  logic                                       last_x, last_y;
  logic [CNT_W-1:0]                           cnt_d;

  // Board edge for a level code; level 0 means no board.
  function automatic logic [NW-1:0] edge_of(input logic [1:0] l);
    case (l)
      2'd1:    return NW'(8);
      2'd2:    return NW'(10);
      2'd3:    return NW'(16);
      default: return '0;
    endcase
  endfunction

  assign n_q    = edge_of(lvl_q);
  assign n_in   = edge_of(level);
  assign last_x = ({1'b0, x_q} == n_q - NW'(1));
  assign last_y = ({1'b0, y_q} == n_q - NW'(1));

  // Neighbour count for the current cell; off-board neighbours (including
  // latched mines beyond the active edge) contribute nothing.
  always_comb begin : count
    int nx, ny;
    cnt_d = '0;
    nx    = 0;
    ny    = 0;
    for (int dx = -1; dx <= 1; dx++) begin
      for (int dy = -1; dy <= 1; dy++) begin
        nx = int'(x_q) + dx;
        ny = int'(y_q) + dy;
        if (!(dx == 0 && dy == 0) && nx >= 0 && ny >= 0 &&
            nx < int'(n_q) && ny < int'(n_q))
          cnt_d = cnt_d + {{(CNT_W-1){1'b0}}, mine_q[nx[IW-1:0]][ny[IW-1:0]]};
      end
    end
  end

  // Next-state and scan-position logic.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    case (state_q)
      IDLE: if (start) begin
        x_d     = '0;
        y_d     = '0;
        state_d = (n_in != '0) ? SCAN : DONE;
      end
      SCAN: begin
        if (last_x) begin
          x_d = '0;
          if (last_y) state_d = DONE;
          else        y_d = y_q + IW'(1);
        end else begin
          x_d = x_q + IW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, snapshot and result registers. done is registered off the DONE
  // state so the pulse lands one cycle after the last cell write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      lvl_q   <= '0;
      mine_q  <= '0;
      num_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      done_q  <= (state_q == DONE);
      if (state_q == IDLE && start) begin
        lvl_q  <= level;
        mine_q <= mine_arr;
        num_q  <= '0;
      end else if (state_q == SCAN) begin
        num_q[x_q][y_q] <= cnt_d;
      end
    end
  end

  assign num_arr = num_q;
  assign busy    = (state_q == SCAN);
  assign done    = done_q;

endmodule

// File: tb/tb_mine_count_gen.sv
// Directed bench for mine_count_gen: each start pushes a hand-computed expected
// board and done cycle; a negedge monitor checks them when done pulses.
module tb_mine_count_gen;

  logic                    clk = 1'b0;
  logic                    rst, start;
  logic [1:0]              level;
  logic [15:0][15:0]       mine;
  logic [15:0][15:0][3:0]  num;
  logic                    busy, done;

  mine_count_gen #(.MAX_DIM(16), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .level(level),
    .mine_arr(mine), .num_arr(num), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0][15:0][3:0] exp;
    logic [15:0][15:0]      care;
    int                     at;
    int                     id;
  } sb_t;

  sb_t q[$];
  int  checks = 0, errors = 0;
  logic [15:0][15:0][3:0] e_arr;
  logic [15:0][15:0]      e_care;
  int  bcnt = 0;
  bit  bcount_en = 0;

  task automatic chk(input bit ok, input string nm, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin : mon
    sb_t e;
    int nbad, bx, by;
    if (bcount_en && busy) bcnt++;
    if (!rst && done) begin
      if (q.size() == 0) chk(1'b0, "unexpected_done", cyc, -1);
      else begin
        e = q.pop_front();
        nbad = 0; bx = -1; by = -1;
        for (int x = 0; x < 16; x++)
          for (int y = 0; y < 16; y++)
            if (e.care[x][y] && num[x][y] !== e.exp[x][y]) begin
              if (nbad == 0) begin bx = x; by = y; end
              nbad++;
            end
        chk(nbad == 0, $sformatf("num_arr t%0d bad cells (first x=%0d y=%0d)", e.id, bx, by), nbad, 0);
        chk(cyc == e.at, $sformatf("done_cycle t%0d", e.id), cyc, e.at);
      end
    end
  end

  task automatic issue(input logic [1:0] lv, input int id, input bit push);
    int n;
    sb_t e;
    n = (lv == 2'd1) ? 8 : (lv == 2'd2) ? 10 : (lv == 2'd3) ? 16 : 0;
    @(negedge clk);
    level = lv;
    start = 1'b1;
    if (push) begin
      e.exp = e_arr; e.care = e_care; e.id = id;
      e.at  = cyc + 1 + n * n + 1;   // accept edge, N*N writes, done register
      q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input int id);
    for (int i = 0; i < 400 && q.size() != 0; i++) @(negedge clk);
    chk(q.size() == 0, $sformatf("done_timeout t%0d pending", id), q.size(), 0);
    q.delete();
  endtask

  task automatic chk_zero(input string nm);
    int nz;
    nz = 0;
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        if (num[x][y] !== 4'd0) nz++;
    chk(nz == 0, nm, nz, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; level = 2'd0; mine = '0;
    repeat (3) @(negedge clk);
    chk(busy == 1'b0, "reset_busy", busy, 0);
    chk(done == 1'b0, "reset_done", done, 0);
    chk_zero("reset_num_nonzero");
    rst = 1'b0;

    // T1: easy, empty board, 64 busy cycles.
    mine = '0; e_arr = '0; e_care = '1;
    bcnt = 0; bcount_en = 1;
    issue(2'd1, 1, 1);
    drain(1);
    bcount_en = 0;
    chk(bcnt == 64, "t1_busy_cycles", bcnt, 64);
    chk(busy == 1'b0, "t1_busy_after", busy, 0);

    // T2: easy, single mine at [3][3].
    mine = '0; mine[3][3] = 1'b1;
    e_arr = '0; e_care = '1;
    for (int x = 2; x <= 4; x++)
      for (int y = 2; y <= 4; y++) e_arr[x][y] = 4'd1;
    e_arr[3][3] = 4'd0;
    issue(2'd1, 2, 1);
    drain(2);

    // T3: hard, full ring around [5][5] plus corner cluster.
    mine = '0;
    for (int dx = -1; dx <= 1; dx++)
      for (int dy = -1; dy <= 1; dy++)
        if (!(dx == 0 && dy == 0)) mine[5+dx][5+dy] = 1'b1;
    mine[0][1] = 1'b1; mine[1][0] = 1'b1; mine[1][1] = 1'b1;
    e_arr = '0; e_care = '0;
    e_care[5][5] = 1'b1; e_arr[5][5] = 4'd8;
    e_care[0][0] = 1'b1; e_arr[0][0] = 4'd3;
    e_care[4][4] = 1'b1; e_arr[4][4] = 4'd2;
    e_care[3][3] = 1'b1; e_arr[3][3] = 4'd1;
    e_care[1][1] = 1'b1; e_arr[1][1] = 4'd2;
    e_care[2][2] = 1'b1; e_arr[2][2] = 4'd1;
    e_care[15][15] = 1'b1;
    issue(2'd3, 3, 1);
    drain(3);

    // T4: medium, corner mine plus a mine outside the board.
    mine = '0; mine[9][9] = 1'b1; mine[12][12] = 1'b1;
    e_arr = '0; e_care = '1;
    e_arr[8][8] = 4'd1; e_arr[8][9] = 4'd1; e_arr[9][8] = 4'd1;
    issue(2'd2, 4, 1);
    drain(4);

    // T5: restart and input changes during the scan are ignored.
    mine = '0; mine[0][0] = 1'b1;
    e_arr = '0; e_care = '1;
    e_arr[0][1] = 4'd1; e_arr[1][0] = 4'd1; e_arr[1][1] = 4'd1;
    issue(2'd1, 5, 1);
    repeat (10) @(negedge clk);
    mine = '1; level = 2'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain(5);
    repeat (4) @(negedge clk);

    // T6: reset mid-scan (start held with it), then a clean rerun.
    mine = '0;
    issue(2'd3, 6, 0);
    repeat (19) @(negedge clk);
    rst = 1'b1; start = 1'b1; level = 2'd1;
    @(negedge clk);
    chk(busy == 1'b0, "t6_busy_after_rst", busy, 0);
    chk(done == 1'b0, "t6_done_after_rst", done, 0);
    chk_zero("t6_num_nonzero_after_rst");
    rst = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    chk(busy == 1'b0, "t6_idle_after_rst", busy, 0);
    mine = '0; mine[7][7] = 1'b1;
    e_arr = '0; e_care = '1;
    e_arr[6][6] = 4'd1; e_arr[6][7] = 4'd1; e_arr[7][6] = 4'd1;
    issue(2'd1, 7, 1);
    drain(7);

    // T8: level 0 clears the board and pulses done right away.
    mine = '1; e_arr = '0; e_care = '1;
    issue(2'd0, 8, 1);
    drain(8);

    repeat (5) @(negedge clk);
    chk(q.size() == 0, "final_queue", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
